// File: rtl/sd_switch_pkg.sv
// rtl/sd_switch_pkg.sv - shared types and constants for the SD SPI bus switch
package sd_switch_pkg;

  typedef enum logic [1:0] {
    STEADY,
    WAIT_IDLE,
    GAP
  } state_t;

  localparam logic SEL_PHYS = 1'b0;
  localparam logic SEL_VIRT = 1'b1;

endpackage

// File: rtl/sd_spi_switch_if.sv
// rtl/sd_spi_switch_if.sv - one SPI SD bus (chip select, clock, data both ways)
interface sd_spi_switch_if;

  logic ss;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output ss, output sck, output mosi, input miso);
  modport slave  (input ss, input sck, input mosi, output miso);

endinterface

// File: rtl/activity_stretch.sv
// rtl/activity_stretch.sv - stretches a per-cycle activity flag into a visible LED pulse
module activity_stretch #(
  parameter int unsigned HOLD = 2_000_000
) (
  input  logic clk_sys,
  input  logic n_reset,
  input  logic act,
  output logic led
);

  localparam int unsigned CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else if (act) begin
      cnt_q <= CW'(HOLD);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign led = act | (cnt_q != '0);

endmodule

// File: rtl/sd_spi_switch.sv
// rtl/sd_spi_switch.sv - routes the core's SPI SD bus to the physical slot or the virtual card,
// committing selection changes only after the host has idled and both targets sat deselected.
module sd_spi_switch
  import sd_switch_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned SWITCH_GAP  = 16,
  parameter int unsigned LED_HOLD    = 2_000_000
) (
  input  logic             clk_sys,
  input  logic             n_reset,
  input  logic             img_mounted,
  input  logic             img_size_nz,
  sd_spi_switch_if.slave   host,
  sd_spi_switch_if.master  vsd,
  sd_spi_switch_if.master  phy,
  output logic             vsd_sel,
  output logic             switching,
  output logic             drive_led
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned GW = $clog2(SWITCH_GAP + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SWITCH_GAP - 1);

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          target_q, target_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [GW-1:0] gap_q, gap_d;

  // Reset lands in GAP so neither card sees a half transaction while the core restarts.
  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= GAP;
      gap_q    <= GAP_LAST;
      sel_q    <= SEL_PHYS;
      target_q <= SEL_PHYS;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      idle_q   <= idle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idle_d   = idle_q;
    gap_d    = gap_q;
    target_d = img_mounted ? img_size_nz : target_q;

    case (state_q)
      STEADY: begin
        if (target_q != sel_q) begin
          state_d = WAIT_IDLE;
          idle_d  = '0;
        end
      end
      WAIT_IDLE: begin
        if (target_q == sel_q) begin
          state_d = STEADY;
        end else if (!host.ss) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = GAP;
          gap_d   = GAP_LAST;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      GAP: begin
        // A mount arriving on the committing cycle still wins.
        if (gap_q == '0) begin
          sel_d   = target_d;
          state_d = STEADY;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = GAP;
        gap_d   = GAP_LAST;
      end
    endcase
  end

  logic in_gap;
  logic route_vsd;
  logic route_phy;

  assign in_gap    = (state_q == GAP);
  assign route_vsd = !in_gap && (sel_q == SEL_VIRT);
  assign route_phy = !in_gap && (sel_q == SEL_PHYS);

  assign vsd.ss    = route_vsd ? host.ss   : 1'b1;
  assign vsd.sck   = route_vsd ? host.sck  : 1'b0;
  assign vsd.mosi  = route_vsd ? host.mosi : 1'b0;
  assign phy.ss    = route_phy ? host.ss   : 1'b1;
  assign phy.sck   = route_phy ? host.sck  : 1'b0;
  assign phy.mosi  = route_phy ? host.mosi : 1'b0;
  assign host.miso = in_gap ? 1'b1 : ((sel_q == SEL_VIRT) ? vsd.miso : phy.miso);

  assign vsd_sel   = sel_q;
  assign switching = (state_q != STEADY);

  logic host_act;
  assign host_act = !host.ss && !in_gap;

  activity_stretch #(
    .HOLD(LED_HOLD)
  ) u_led (
    .clk_sys (clk_sys),
    .n_reset (n_reset),
    .act     (host_act),
    .led     (drive_led)
  );

endmodule
